// File: rtl/isa_pkg.sv
// Shared ISA constants for the fetch and execute stages: opcodes that steer
// the PC, branch condition codes, fetch state encodings and offset helpers.
package isa_pkg;

  // Opcodes (instr[15:12]) that change control flow, matching the decoder
  localparam logic [3:0] bOp   = 4'hC;
  localparam logic [3:0] jalOp = 4'hD;
  localparam logic [3:0] jrOp  = 4'hE;
  localparam logic [3:0] hltOp = 4'hF;

  // Branch condition codes (instr[11:9] of a bOp instruction)
  localparam logic [2:0] CC_NE = 3'b000;  // !Z
  localparam logic [2:0] CC_EQ = 3'b001;  // Z
  localparam logic [2:0] CC_GT = 3'b010;  // !Z & !N
  localparam logic [2:0] CC_LT = 3'b011;  // N
  localparam logic [2:0] CC_GE = 3'b100;  // !N
  localparam logic [2:0] CC_LE = 3'b101;  // N | Z
  localparam logic [2:0] CC_VS = 3'b110;  // V
  localparam logic [2:0] CC_AL = 3'b111;  // always

  // Fetch state encodings
  localparam logic [1:0] FS_BOOT   = 2'd0;
  localparam logic [1:0] FS_FETCH  = 2'd1;
  localparam logic [1:0] FS_ISSUE  = 2'd2;
  localparam logic [1:0] FS_HALTED = 2'd3;

  // Sign-extend a 9-bit branch offset to PC width
  function automatic logic [15:0] sext9(input logic [8:0] v);
    return {{7{v[8]}}, v};
  endfunction

  // Sign-extend a 12-bit JAL offset to PC width
  function automatic logic [15:0] sext12(input logic [11:0] v);
    return {{4{v[11]}}, v};
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator: maps a 3-bit condition code and the Z/N/V
// flags to a taken decision. Purely combinational so execute can reuse it.
module branch_cond
  import isa_pkg::*;
(
  input  logic [2:0] cond_i,
  input  logic       flag_z_i,
  input  logic       flag_n_i,
  input  logic       flag_v_i,
  output logic       taken_o
);

  // Decode the condition code against the current flags
  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      CC_NE:   taken_o = !flag_z_i;
      CC_EQ:   taken_o = flag_z_i;
      CC_GT:   taken_o = !flag_z_i && !flag_n_i;
      CC_LT:   taken_o = flag_n_i;
      CC_GE:   taken_o = !flag_n_i;
      CC_LE:   taken_o = flag_n_i || flag_z_i;
      CC_VS:   taken_o = flag_v_i;
      CC_AL:   taken_o = 1'b1;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: holds the PC, fetches 16-bit words from a
// variable-latency memory, presents them to decode and computes the next PC
// when execute commits. Optional retired-instruction counter is built only
// when FETCH_RETIRE_CNT_EN is defined; otherwise retired_cnt reads zero.
module instr_fetch
  import isa_pkg::*;
#(
  parameter logic [15:0] BOOT_ADDR = 16'h0000
)(
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_re,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_rdy,
  output logic [15:0] instr,
  output logic [15:0] pc,
  output logic [15:0] pc_plus1,
  output logic        instr_vld,
  input  logic        commit,
  input  logic        flag_z,
  input  logic        flag_n,
  input  logic        flag_v,
  input  logic [15:0] jr_tgt,
  output logic        halted,
  output logic [15:0] retired_cnt
);

  logic [1:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_plus1_s;
  logic [15:0] npc_s;
  logic [3:0]  opcode_s;
  logic        taken_s;
  logic        commit_acc_s;

  assign opcode_s     = instr_q[15:12];
  assign pc_plus1_s   = pc_q + 16'd1;
  assign commit_acc_s = (state_q == FS_ISSUE) && commit;

  branch_cond u_branch_cond (
    .cond_i   (instr_q[11:9]),
    .flag_z_i (flag_z),
    .flag_n_i (flag_n),
    .flag_v_i (flag_v),
    .taken_o  (taken_s)
  );

  // Next-PC selection; only consumed in the commit cycle, so flags and
  // jr_tgt are effectively sampled there and nowhere else
  always_comb begin
    npc_s = pc_plus1_s;
    case (opcode_s)
      bOp: begin
        if (taken_s) begin
          npc_s = pc_plus1_s + sext9(instr_q[8:0]);
        end else begin
          npc_s = pc_plus1_s;
        end
      end
      jalOp:   npc_s = pc_plus1_s + sext12(instr_q[11:0]);
      jrOp:    npc_s = jr_tgt;
      hltOp:   npc_s = pc_q;
      default: npc_s = pc_plus1_s;
    endcase
  end

  // Fetch sequencer: BOOT -> FETCH -> ISSUE -> FETCH ... -> HALTED
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      FS_BOOT: begin
        state_d = FS_FETCH;
      end
      FS_FETCH: begin
        if (imem_rdy) begin
          instr_d = imem_rdata;
          state_d = FS_ISSUE;
        end else begin
          state_d = FS_FETCH;
        end
      end
      FS_ISSUE: begin
        if (commit) begin
          pc_d = npc_s;
          if (opcode_s == hltOp) begin
            state_d = FS_HALTED;
          end else begin
            state_d = FS_FETCH;
          end
        end else begin
          state_d = FS_ISSUE;
        end
      end
      FS_HALTED: begin
        state_d = FS_HALTED;
      end
      default: begin
        state_d = FS_BOOT;
      end
    endcase
  end

  // State, PC and instruction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FS_BOOT;
      pc_q    <= BOOT_ADDR;
      instr_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Outputs decode from registered state only; no path from imem_rdy
  assign imem_re   = (state_q == FS_FETCH);
  assign imem_addr = pc_q;
  assign instr_vld = (state_q == FS_ISSUE);
  assign halted    = (state_q == FS_HALTED);
  assign instr     = instr_q;
  assign pc        = pc_q;
  assign pc_plus1  = pc_plus1_s;

`ifdef FETCH_RETIRE_CNT_EN
  logic [15:0] retired_q, retired_d;

  assign retired_d = commit_acc_s ? (retired_q + 16'd1) : retired_q;

  // Retired-instruction counter, wraps naturally at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= 16'h0000;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired_cnt = retired_q;
`else
  logic unused_s;
  assign unused_s    = commit_acc_s;
  assign retired_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: randomized memory latency, instruction
// mix and flags, checked by a scoreboard against a behavioural next-PC model.
module tb_instr_fetch;

  localparam logic [15:0] BOOT = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_re;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = 16'h0000;
  logic        imem_rdy = 1'b0;
  logic [15:0] instr;
  logic [15:0] pc;
  logic [15:0] pc_plus1;
  logic        instr_vld;
  logic        commit = 1'b0;
  logic        flag_z = 1'b0;
  logic        flag_n = 1'b0;
  logic        flag_v = 1'b0;
  logic [15:0] jr_tgt = 16'h0000;
  logic        halted;
  logic [15:0] retired_cnt;

  instr_fetch #(.BOOT_ADDR(BOOT)) dut (
    .clk(clk), .rst_n(rst_n), .imem_re(imem_re), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_rdy(imem_rdy), .instr(instr), .pc(pc),
    .pc_plus1(pc_plus1), .instr_vld(instr_vld), .commit(commit),
    .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v), .jr_tgt(jr_tgt),
    .halted(halted), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ins;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] model_pc = BOOT;
  int          model_retired = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference next-PC rule written with plain integer arithmetic
  function automatic logic [15:0] model_next(input logic [15:0] p, input logic [15:0] ins,
                                             input logic z, input logic n, input logic v,
                                             input logic [15:0] jr);
    int off;
    bit take;
    logic [15:0] r;
    r = 16'(int'(p) + 1);
    case (ins[15:12])
      4'hC: begin
        case (ins[11:9])
          3'd0: take = !z;
          3'd1: take = z;
          3'd2: take = !z && !n;
          3'd3: take = n;
          3'd4: take = !n;
          3'd5: take = n || z;
          3'd6: take = v;
          default: take = 1'b1;
        endcase
        off = int'(ins[8:0]);
        if (off > 255) off -= 512;
        if (take) r = 16'(int'(p) + 1 + off);
      end
      4'hD: begin
        off = int'(ins[11:0]);
        if (off > 2047) off -= 4096;
        r = 16'(int'(p) + 1 + off);
      end
      4'hE: r = jr;
      4'hF: r = p;
      default: r = 16'(int'(p) + 1);
    endcase
    return r;
  endfunction

  // Monitor: pop the scoreboard whenever a new instruction is presented and
  // require it to stay stable while instr_vld is held
  logic vld_prev = 1'b0;
  exp_t cur;
  always @(negedge clk) begin
    if (!rst_n) begin
      vld_prev = 1'b0;
    end else begin
      if (instr_vld && !vld_prev) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_issue: got pc %h instr %h, expected none", pc, instr);
          cur = '{pc: pc, ins: instr};
        end else begin
          cur = sb_q.pop_front();
          check("issue_pc", pc, cur.pc);
          check("issue_instr", instr, cur.ins);
          check("issue_pc_plus1", pc_plus1, 16'(cur.pc + 16'd1));
        end
      end else if (instr_vld) begin
        check("hold_pc", pc, cur.pc);
        check("hold_instr", instr, cur.ins);
      end
      vld_prev = instr_vld;
    end
  end

  // Fetch one instruction with the given latency, then commit it
  task automatic run_instr(input logic [15:0] ins, input int lat,
                           input logic z, input logic n, input logic v,
                           input logic [15:0] jr, input int cdelay);
    int waited;
    logic [15:0] nxt;
    waited = 0;
    while (!imem_re && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    if (!imem_re) begin
      n_checks++;
      n_errors++;
      $display("FAIL fetch_timeout: got imem_re=0, expected 1 within 8 cycles");
    end
    check("fetch_addr", imem_addr, model_pc);
    check("halted_running", {15'd0, halted}, 16'd0);
    for (int i = 0; i < lat; i++) begin
      imem_rdy = 1'b0;
      commit = 1'($urandom_range(0, 1));
      @(negedge clk);
      commit = 1'b0;
      check("wait_re", {15'd0, imem_re}, 16'd1);
      check("wait_addr", imem_addr, model_pc);
      check("wait_vld", {15'd0, instr_vld}, 16'd0);
    end
    imem_rdy = 1'b1;
    imem_rdata = ins;
    sb_q.push_back('{pc: model_pc, ins: ins});
    @(negedge clk);
    imem_rdy = 1'b0;
    for (int i = 0; i < cdelay; i++) begin
      imem_rdy = 1'($urandom_range(0, 1));
      imem_rdata = 16'($urandom);
      flag_z = 1'($urandom); flag_n = 1'($urandom); flag_v = 1'($urandom);
      jr_tgt = 16'($urandom);
      @(negedge clk);
    end
    imem_rdy = 1'b0;
    check("vld_before_commit", {15'd0, instr_vld}, 16'd1);
    commit = 1'b1;
    flag_z = z; flag_n = n; flag_v = v; jr_tgt = jr;
    nxt = model_next(model_pc, ins, z, n, v, jr);
    @(negedge clk);
    commit = 1'b0;
    flag_z = 1'($urandom); flag_n = 1'($urandom); flag_v = 1'($urandom);
    jr_tgt = 16'($urandom);
    model_pc = nxt;
    model_retired++;
    check("vld_after_commit", {15'd0, instr_vld}, 16'd0);
`ifdef FETCH_RETIRE_CNT_EN
    check("retired_cnt", retired_cnt, 16'(model_retired));
`else
    check("retired_cnt", retired_cnt, 16'h0000);
`endif
  endtask

  // Random instruction excluding HLT
  function automatic logic [15:0] rand_instr();
    int k;
    k = $urandom_range(0, 9);
    if (k <= 2) return {4'hC, 12'($urandom)};
    if (k == 3) return {4'hD, 12'($urandom)};
    if (k == 4) return {4'hE, 12'($urandom)};
    return {4'($urandom_range(0, 11)), 12'($urandom)};
  endfunction

  task automatic run_random(input int count);
    for (int i = 0; i < count; i++) begin
      run_instr(rand_instr(), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                1'($urandom), 16'($urandom), $urandom_range(0, 2));
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"}, pc, BOOT);
    check({tag, "_instr"}, instr, 16'h0000);
    check({tag, "_vld"}, {15'd0, instr_vld}, 16'd0);
    check({tag, "_re"}, {15'd0, imem_re}, 16'd0);
    check({tag, "_halted"}, {15'd0, halted}, 16'd0);
    check({tag, "_retired"}, retired_cnt, 16'h0000);
  endtask

  // Release reset together with a stray imem_rdy pulse that must be ignored
  task automatic release_reset();
    rst_n = 1'b1;
    imem_rdy = 1'b1;
    imem_rdata = 16'hA5A5;
    #1;
    check("release_re", {15'd0, imem_re}, 16'd0);
    @(negedge clk);
    imem_rdy = 1'b0;
    check("boot_re", {15'd0, imem_re}, 16'd1);
    check("boot_addr", imem_addr, BOOT);
    check("boot_instr", instr, 16'h0000);
    check("boot_vld", {15'd0, instr_vld}, 16'd0);
    model_pc = BOOT;
    model_retired = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    release_reset();

    // Directed cases
    run_instr(16'h0123, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 0);
    check("seq_next", model_pc, 16'h0001);
    run_instr(16'hE000, 1, 1'b0, 1'b0, 1'b0, 16'h0005, 1);
    run_instr(16'hE000, 3, 1'b0, 1'b0, 1'b0, 16'h0010, 0);
    run_instr(16'hC1FE, 0, 1'b1, 1'b0, 1'b0, 16'h0000, 1);
    run_instr(16'hE000, 0, 1'b0, 1'b0, 1'b0, 16'h0010, 0);
    run_instr(16'hC1FE, 2, 1'b0, 1'b1, 1'b1, 16'h0000, 0);
    run_instr(16'hE000, 0, 1'b0, 1'b0, 1'b0, 16'h0800, 0);
    run_instr(16'hD7FF, 1, 1'b0, 1'b0, 1'b0, 16'h0000, 2);
    run_instr(16'hE000, 0, 1'b0, 1'b0, 1'b0, 16'hBEEF, 0);
    run_instr(16'hE000, 0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 0);
    run_instr(16'h1234, 1, 1'b0, 1'b0, 1'b0, 16'h0000, 0);
    run_instr(16'hCFFE, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 0);
    run_instr(16'hD800, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 0);

    run_random(150);

    // Reset while a fetch is outstanding
    while (!imem_re) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_state("midfetch");
    @(negedge clk);
    release_reset();
    run_instr(16'h0123, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 0);
    run_random(40);

    // Halt and stay halted
    run_instr(16'hF000, 2, 1'b0, 1'b0, 1'b0, 16'h0000, 1);
    for (int i = 0; i < 6; i++) begin
      imem_rdy = 1'($urandom);
      commit = 1'($urandom);
      @(negedge clk);
      check("halted", {15'd0, halted}, 16'd1);
      check("halted_re", {15'd0, imem_re}, 16'd0);
      check("halted_vld", {15'd0, instr_vld}, 16'd0);
    end
    imem_rdy = 1'b0;
    commit = 1'b0;
    check("halted_pc", pc, model_pc);
    check("sb_empty", 16'(sb_q.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
